mem_stage: RTL and testbench

- Memory-access stage that consumes the execute stage's result. Inputs are the ALU result/address (exeOut), store data (RegData1_o), the stack pointer (SPOut) and the 5-bit opcode.
- Issues single-word load, store, PUSH and POP transactions to data memory over a req/ack handshake.
- Produces writeback data and stack-pointer updates, and stalls the upstream pipeline while a transaction is in flight.
- Non-memory opcodes pass through with one cycle of latency.

---
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
interface mem_stage_if #(parameter int DATA_W = 32) ();
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: LD/ST/PUSH/POP over a req/ack bus, pass-through otherwise.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an execute-stage result
// REQ   | memory request outstanding, bus fields held stable
// RESP  | wb_valid pulse; a new result may be accepted in the same cycle
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] exeOut,
  input  logic [DATA_W-1:0] RegData1_o,
  input  logic [DATA_W-1:0] SPOut,
  mem_stage_if.master       mem,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              sp_we,
  output logic [DATA_W-1:0] sp_new,
  output logic              misalign,
  output logic              mem_err
);

  localparam logic [4:0] OP_LD   = 5'b01101;
  localparam logic [4:0] OP_ST   = 5'b01110;
  localparam logic [4:0] OP_PUSH = 5'b01111;
  localparam logic [4:0] OP_POP  = 5'b10000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic              is_mem, is_read, is_sp, aligned, accept;
  logic [DATA_W-1:0] addr_sel;
  logic              op_read, op_sp;
  logic [DATA_W-1:0] sp_lat;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_comb begin
    is_mem  = 1'b0;
    is_read = 1'b0;
    is_sp   = 1'b0;
    case (opcode)
      OP_LD:   begin is_mem = 1'b1; is_read = 1'b1; end
      OP_ST:   is_mem = 1'b1;
      OP_PUSH: begin is_mem = 1'b1; is_sp = 1'b1; end
      OP_POP:  begin is_mem = 1'b1; is_read = 1'b1; is_sp = 1'b1; end
      default: ;
    endcase
  end

  // POP reads at the current SP; every other memory op addresses exeOut
  assign addr_sel = (opcode == OP_POP) ? SPOut : exeOut;
  assign aligned  = (addr_sel[1:0] == 2'b00);

  // RESP lasts one cycle, so readiness returns alongside the wb_valid pulse
  assign in_ready    = (state == IDLE) || (state == RESP);
  assign accept      = in_valid && in_ready;
  assign mem.mem_req = (state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      sp_we         <= 1'b0;
      sp_new        <= '0;
      misalign      <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      op_read       <= 1'b0;
      op_sp         <= 1'b0;
      sp_lat        <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt           <= '0;
      mem_err       <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      sp_we    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            op_read <= is_read;
            op_sp   <= is_sp;
            sp_lat  <= exeOut;
            if (!is_mem) begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_data  <= exeOut;
            end else if (!aligned) begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_data  <= '0;
              misalign <= 1'b1;
            end else begin
              state         <= REQ;
              mem.mem_we    <= !is_read;
              mem.mem_addr  <= addr_sel;
              mem.mem_wdata <= RegData1_o;
`ifdef MEM_TIMEOUT_EN
              cnt           <= CNT_LOAD;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_data  <= op_read ? mem.mem_rdata : '0;
            if (op_sp) begin
              sp_we  <= 1'b1;
              sp_new <= sp_lat;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (cnt == '0) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_data  <= '0;
            mem_err  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_TIMEOUT_EN
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; bus responses are driven by hand.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [31:0] exeOut, RegData1_o, SPOut;
  logic        wb_valid, sp_we, misalign, mem_err;
  logic [31:0] wb_data, sp_new;
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_stage_if #(.DATA_W(32)) mif ();

  mem_stage #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .exeOut     (exeOut),
    .RegData1_o (RegData1_o),
    .SPOut      (SPOut),
    .mem        (mif),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .sp_we      (sp_we),
    .sp_new     (sp_new),
    .misalign   (misalign),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = 5'd0; exeOut = '0;
    RegData1_o = '0; SPOut = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_sp_we", 32'(sp_we), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    // non-memory pass-through, latency 1
    in_valid = 1'b1; opcode = 5'b00001; exeOut = 32'h1234;
    tick();
    in_valid = 1'b0;
    chk("nm_wb_valid", 32'(wb_valid), 32'd1);
    chk("nm_wb_data", wb_data, 32'h1234);
    chk("nm_mem_req", 32'(mif.mem_req), 32'd0);
    chk("nm_sp_we", 32'(sp_we), 32'd0);
    chk("nm_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("nm_pulse_end", 32'(wb_valid), 32'd0);
    chk("nm_wb_hold", wb_data, 32'h1234);

    // LD with ack in the third request cycle
    in_valid = 1'b1; opcode = 5'b01101; exeOut = 32'h40;
    tick();
    in_valid = 1'b0;
    chk("ld_req_c1", 32'(mif.mem_req), 32'd1);
    chk("ld_we", 32'(mif.mem_we), 32'd0);
    chk("ld_addr", mif.mem_addr, 32'h40);
    chk("ld_in_ready_c1", 32'(in_ready), 32'd0);
    tick();
    chk("ld_req_c2", 32'(mif.mem_req), 32'd1);
    chk("ld_in_ready_c2", 32'(in_ready), 32'd0);
    tick();
    chk("ld_req_c3", 32'(mif.mem_req), 32'd1);
    chk("ld_addr_c3", mif.mem_addr, 32'h40);
    chk("ld_no_wb_yet", 32'(wb_valid), 32'd0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
    tick();
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    chk("ld_req_drop", 32'(mif.mem_req), 32'd0);
    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_sp_we", 32'(sp_we), 32'd0);
    chk("ld_in_ready", 32'(in_ready), 32'd1);
    tick();

    // PUSH with immediate ack
    in_valid = 1'b1; opcode = 5'b01111; SPOut = 32'h100; exeOut = 32'hFC; RegData1_o = 32'd7;
    tick();
    in_valid = 1'b0;
    chk("push_req", 32'(mif.mem_req), 32'd1);
    chk("push_we", 32'(mif.mem_we), 32'd1);
    chk("push_addr", mif.mem_addr, 32'hFC);
    chk("push_wdata", mif.mem_wdata, 32'd7);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    chk("push_wb_valid", 32'(wb_valid), 32'd1);
    chk("push_sp_we", 32'(sp_we), 32'd1);
    chk("push_sp_new", sp_new, 32'hFC);
    tick();
    chk("push_sp_we_end", 32'(sp_we), 32'd0);

    // POP reads at SPOut, sp_new from exeOut
    in_valid = 1'b1; opcode = 5'b10000; SPOut = 32'hFC; exeOut = 32'h100;
    tick();
    in_valid = 1'b0;
    chk("pop_req", 32'(mif.mem_req), 32'd1);
    chk("pop_we", 32'(mif.mem_we), 32'd0);
    chk("pop_addr", mif.mem_addr, 32'hFC);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'd7;
    tick();
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    chk("pop_wb_data", wb_data, 32'd7);
    chk("pop_sp_new", sp_new, 32'h100);
    chk("pop_sp_we", 32'(sp_we), 32'd1);
    tick();

    // misaligned ST: no request, sticky flag
    in_valid = 1'b1; opcode = 5'b01110; exeOut = 32'h42; RegData1_o = 32'h99;
    tick();
    in_valid = 1'b0;
    chk("mis_req", 32'(mif.mem_req), 32'd0);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_wb_data", wb_data, 32'd0);
    chk("mis_sp_we", 32'(sp_we), 32'd0);
    tick();
    chk("mis_sticky", 32'(misalign), 32'd1);
    chk("mis_req_after", 32'(mif.mem_req), 32'd0);

    // stray ack while idle is ignored
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h5A5A;
    tick();
    mif.mem_ack = 1'b0;
    chk("stray_ack_wb", 32'(wb_valid), 32'd0);
    chk("stray_ack_ready", 32'(in_ready), 32'd1);

    // in_valid while busy is not accepted
    in_valid = 1'b1; opcode = 5'b01101; exeOut = 32'h80;
    tick();
    opcode = 5'b00001; exeOut = 32'h55;
    tick();
    in_valid = 1'b0;
    chk("busy_ready", 32'(in_ready), 32'd0);
    chk("busy_addr", mif.mem_addr, 32'h80);
    chk("busy_no_wb", 32'(wb_valid), 32'd0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFE;
    tick();
    mif.mem_ack = 1'b0;
    chk("busy_ld_data", wb_data, 32'hCAFE);
    tick();
    chk("busy_no_ghost", 32'(wb_valid), 32'd0);
    chk("busy_wb_hold", wb_data, 32'hCAFE);

    // never-acked LD: timeout after 4 request cycles, or waits indefinitely
    in_valid = 1'b1; opcode = 5'b01101; exeOut = 32'h60;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("to_req_c4", 32'(mif.mem_req), 32'd1);
    tick();
`ifdef MEM_TIMEOUT_EN
    chk("to_req_drop", 32'(mif.mem_req), 32'd0);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_wb_data", wb_data, 32'd0);
    tick();
    in_valid = 1'b1; opcode = 5'b01101; exeOut = 32'h20;
    tick();
    in_valid = 1'b0;
`else
    tick(); tick();
    chk("nto_req_held", 32'(mif.mem_req), 32'd1);
    chk("nto_mem_err", 32'(mem_err), 32'd0);
`endif

    // reset while a request is outstanding
    chk("rr_req_before", 32'(mif.mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_req", 32'(mif.mem_req), 32'd0);
    chk("rr_ready", 32'(in_ready), 32'd1);
    chk("rr_misalign", 32'(misalign), 32'd0);
    chk("rr_mem_err", 32'(mem_err), 32'd0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1111;
    tick();
    mif.mem_ack = 1'b0;
    chk("rr_late_ack", 32'(wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
